led_scan_ctrl: RTL
==================

LED_SCAN_CTRL -- requirements
Module: led_scan_ctrl

Interface
REQ-001 SHALL have parameter PWM_WIDTH, default 12: bits per colour channel and of pwmlvl.
REQ-002 SHALL have parameter COLS, default 32: columns shifted per row.
REQ-003 SHALL have parameter ROWS, default 16: scan rows; top and bottom halves are driven together.
REQ-004 SHALL have parameter SHOW_CYCLES, default 64: cycles oe_n is held low per row.
REQ-005 Clock: clk, input, 1 bit, system clock; all logic is on its rising edge.
REQ-006 Reset: rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-007 enable, input, 1 bit: start and continue scanning.
REQ-008 rd_en, output, 1 bit: pixel memory read strobe.
REQ-009 rd_addr, output, log2(ROWS)+log2(COLS) bits: read address {row, col}.
REQ-010 rd_data, input, 6*PWM_WIDTH bits: {top r,g,b, bottom r,g,b}, valid the cycle after rd_en.
REQ-011 pwmlvl, output, PWM_WIDTH bits: compare level for the downstream comparators.
REQ-012 top_r, top_g, top_b, bot_r, bot_g, bot_b, outputs, PWM_WIDTH bits each: registered pixel values for the comparators.
REQ-013 sclk, latch, oe_n, outputs, 1 bit each: panel shift clock, latch, and active-low output enable.
REQ-014 row_addr, output, log2(ROWS) bits: panel row select.
REQ-015 frame_start, output, 1 bit: one-cycle pulse marking the start of each frame.

Function
REQ-016 The state machine SHALL have states IDLE, FETCH, SHIFT, BLANK, LATCH and SHOW.
REQ-017 IDLE -> FETCH SHALL occur when enable=1; otherwise IDLE holds, with oe_n=1 and sclk=0.
REQ-018 FETCH SHALL last 2 cycles; rd_en=1 with rd_addr={row,0} in the first cycle only.
REQ-019 SHIFT SHALL last 2*COLS cycles; column k uses phase A (sclk=0), then phase B (sclk=1).
REQ-020 The px outputs SHALL be loaded from rd_data on the edge entering phase A of column k and SHALL hold through phase B.
REQ-021 In phase A of column k < COLS-1, rd_en SHALL be 1 with rd_addr={row,k+1}; rd_en SHALL be 0 at all other times.
REQ-022 BLANK SHALL last 1 cycle with oe_n=1; row_addr SHALL update to the current row on the edge entering BLANK.
REQ-023 LATCH SHALL last 1 cycle with latch=1 and oe_n=1.
REQ-024 SHOW SHALL last SHOW_CYCLES cycles with oe_n=0.
REQ-025 On leaving SHOW, row SHALL increment; if row was ROWS-1, row SHALL wrap to 0 and pwmlvl SHALL increment modulo 2^PWM_WIDTH (2^PWM_WIDTH-1 -> 0).
REQ-026 Leaving SHOW SHALL go to FETCH if enable=1, else to IDLE.
REQ-027 If enable drops mid-row, the current row SHALL complete through SHOW first; no truncated row is allowed.
REQ-028 frame_start SHALL pulse in the first FETCH cycle of row 0.
REQ-029 pwmlvl SHALL change only when leaving SHOW, so it is stable during SHIFT.
REQ-030 Row period SHALL be exactly 2+2*COLS+1+1+SHOW_CYCLES cycles.
REQ-031 oe_n SHALL never be 0 while sclk=1 or latch=1.

Reset
REQ-032 While rst_n=0, the block SHALL be in IDLE with row=0, pwmlvl=0, all px outputs=0, sclk=0, latch=0, oe_n=1, rd_en=0, rd_addr=0, row_addr=0 and frame_start=0.
REQ-033 Reset asserted mid-row SHALL force these values immediately, asynchronously, with no completion of the row.
REQ-034 After rst_n rises, the block SHALL stay in IDLE until enable=1 is sampled.

Structure
REQ-035 The state enum and PWM_WIDTH default SHALL live in the shared package led_panel_pkg.
REQ-036 There SHALL be a single module with no sub-module; comparators stay external and combinational.

Verification (COLS=4, ROWS=2, SHOW_CYCLES=3, PWM_WIDTH=4; row period 15 cycles)
REQ-037 Reset release with enable=1 -> frame_start 1 cycle later; rd_addr sequence {0,0},{0,1},{0,2},{0,3} spaced 2 cycles apart; 4 sclk rising edges; latch pulse at cycle 11; oe_n low for cycles 12-14.
REQ-038 Memory model returning data = address at each column -> px value at every sclk rise equals the column index; no change of px while sclk=1.
REQ-039 Run 32 rows (16 frames) -> pwmlvl steps 0..15 then wraps to 0; frame_start pulses every 30 cycles.
REQ-040 enable dropped in SHIFT of row 1 -> row 1 completes LATCH and SHOW, then IDLE with oe_n=1; no further rd_en.
REQ-041 rst_n pulsed low during SHOW -> oe_n=1, pwmlvl=0 and row_addr=0 in the same cycle; restart is clean on enable.
REQ-042 Every cycle of every run: assert oe_n=1 whenever sclk=1 or latch=1, and rd_en at most once per 2 cycles.

Source files
------------

// File: rtl/led_panel_pkg.sv
// Shared definitions for the LED panel scan controller family.
package led_panel_pkg;

  // Default bit depth of each colour channel and of the PWM compare level.
  localparam int PWM_WIDTH_DEFAULT = 12;

  // Scan controller states, one row of the panel is FETCH..SHOW.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    SHIFT = 3'd2,
    BLANK = 3'd3,
    LATCH = 3'd4,
    SHOW  = 3'd5
  } scan_state_t;

endpackage

// File: rtl/led_scan_ctrl.sv
// HUB75-style LED panel scan controller: fetches one row pair from pixel
// memory, shifts it out column by column, latches it and shows it for a
// fixed time, stepping the PWM compare level once per frame.
module led_scan_ctrl
  import led_panel_pkg::*;
#(
  parameter int PWM_WIDTH   = PWM_WIDTH_DEFAULT,
  parameter int COLS        = 32,
  parameter int ROWS        = 16,
  parameter int SHOW_CYCLES = 64
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 enable,
  output logic                                 rd_en,
  output logic [$clog2(ROWS)+$clog2(COLS)-1:0] rd_addr,
  input  logic [6*PWM_WIDTH-1:0]               rd_data,
  output logic [PWM_WIDTH-1:0]                 pwmlvl,
  output logic [PWM_WIDTH-1:0]                 top_r,
  output logic [PWM_WIDTH-1:0]                 top_g,
  output logic [PWM_WIDTH-1:0]                 top_b,
  output logic [PWM_WIDTH-1:0]                 bot_r,
  output logic [PWM_WIDTH-1:0]                 bot_g,
  output logic [PWM_WIDTH-1:0]                 bot_b,
  output logic                                 sclk,
  output logic                                 latch,
  output logic                                 oe_n,
  output logic [$clog2(ROWS)-1:0]              row_addr,
  output logic                                 frame_start
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int SW = $clog2(SHOW_CYCLES + 1);

  localparam logic [RW-1:0] LAST_ROW   = RW'(ROWS - 1);
  localparam logic [CW-1:0] LAST_COL   = CW'(COLS - 1);
  localparam logic [CW-1:0] PENULT_COL = CW'(COLS - 2);
  localparam logic [SW-1:0] LAST_SHOW  = SW'(SHOW_CYCLES - 1);

  scan_state_t   state;
  logic [RW-1:0] row;
  logic [RW-1:0] next_row;
  logic [CW-1:0] col;
  logic          fetch_second;
  logic [SW-1:0] show_cnt;
  logic          load_px;

  // Row that follows the current one, wrapping at the bottom of the panel.
  always_comb begin
    next_row = (row == LAST_ROW) ? '0 : row + RW'(1);
  end

  // Pixel registers take memory data on the edge that enters phase A of a
  // column: end of the second FETCH cycle, or end of the previous phase B.
  always_comb begin
    load_px = ((state == FETCH) && fetch_second) ||
              ((state == SHIFT) && sclk && (col != LAST_COL));
  end

  // Pixel registers feeding the external comparators, held through phase B.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_r <= '0;
      top_g <= '0;
      top_b <= '0;
      bot_r <= '0;
      bot_g <= '0;
      bot_b <= '0;
    end else if (load_px) begin
      top_r <= rd_data[6*PWM_WIDTH-1 -: PWM_WIDTH];
      top_g <= rd_data[5*PWM_WIDTH-1 -: PWM_WIDTH];
      top_b <= rd_data[4*PWM_WIDTH-1 -: PWM_WIDTH];
      bot_r <= rd_data[3*PWM_WIDTH-1 -: PWM_WIDTH];
      bot_g <= rd_data[2*PWM_WIDTH-1 -: PWM_WIDTH];
      bot_b <= rd_data[PWM_WIDTH-1:0];
    end
  end

  // Scan sequencer with registered panel and memory-read outputs; a started
  // row always runs through SHOW, enable is only looked at in IDLE and when
  // leaving SHOW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      row          <= '0;
      col          <= '0;
      fetch_second <= 1'b0;
      show_cnt     <= '0;
      pwmlvl       <= '0;
      sclk         <= 1'b0;
      latch        <= 1'b0;
      oe_n         <= 1'b1;
      rd_en        <= 1'b0;
      rd_addr      <= '0;
      row_addr     <= '0;
      frame_start  <= 1'b0;
    end else begin
      rd_en       <= 1'b0;
      frame_start <= 1'b0;
      latch       <= 1'b0;
      case (state)
        IDLE: begin
          sclk <= 1'b0;
          oe_n <= 1'b1;
          if (enable) begin
            state        <= FETCH;
            fetch_second <= 1'b0;
            rd_en        <= 1'b1;
            rd_addr      <= {row, {CW{1'b0}}};
            frame_start  <= (row == '0);
          end
        end
        FETCH: begin
          if (!fetch_second) begin
            fetch_second <= 1'b1;
          end else begin
            state <= SHIFT;
            col   <= '0;
            sclk  <= 1'b0;
            if (COLS > 1) begin
              rd_en   <= 1'b1;
              rd_addr <= {row, CW'(1)};
            end
          end
        end
        SHIFT: begin
          if (!sclk) begin
            sclk <= 1'b1;
          end else if (col == LAST_COL) begin
            state    <= BLANK;
            sclk     <= 1'b0;
            row_addr <= row;
          end else begin
            col  <= col + CW'(1);
            sclk <= 1'b0;
            if (col != PENULT_COL) begin
              rd_en   <= 1'b1;
              rd_addr <= {row, col + CW'(2)};
            end
          end
        end
        BLANK: begin
          state <= LATCH;
          latch <= 1'b1;
        end
        LATCH: begin
          state    <= SHOW;
          oe_n     <= 1'b0;
          show_cnt <= '0;
        end
        SHOW: begin
          if (show_cnt == LAST_SHOW) begin
            oe_n <= 1'b1;
            row  <= next_row;
            if (row == LAST_ROW) begin
              pwmlvl <= pwmlvl + PWM_WIDTH'(1);
            end
            if (enable) begin
              state        <= FETCH;
              fetch_second <= 1'b0;
              rd_en        <= 1'b1;
              rd_addr      <= {next_row, {CW{1'b0}}};
              frame_start  <= (next_row == '0);
            end else begin
              state <= IDLE;
            end
          end else begin
            show_cnt <= show_cnt + SW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
